instruction_memory: RTL

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_memory.sv
// Loadable instruction store: a program is streamed in word by word, then served by registered single-cycle fetches.
// Optional feature: define IMEM_PARITY_EN to store and recheck one even-parity bit per word.
module instruction_memory #(
    parameter int WORD_SIZE  = 8,
    parameter int NUM_INS    = 16,
    parameter int INDEX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [WORD_SIZE-1:0]  load_data,
    input  logic                  load_par_inv,
    output logic                  load_ready,
    output logic                  load_done,
    input  logic                  fetch_en,
    input  logic [INDEX_SIZE-1:0] prog_count,
    output logic [WORD_SIZE-1:0]  ins_val,
    output logic                  ins_valid,
    output logic                  busy,
    output logic                  parity_err
);

    // Handshake: a load word is taken on every rising edge where load_valid && load_ready;
    // load_ready depends only on the registered state, never on load_valid.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [INDEX_SIZE-1:0] LAST_IDX  = INDEX_SIZE'(NUM_INS - 1);
    localparam logic [INDEX_SIZE:0]   NUM_INS_W = (INDEX_SIZE + 1)'(NUM_INS);

    state_t                state_q;
    state_t                state_d;
    logic [INDEX_SIZE-1:0] ptr_q;
    logic [WORD_SIZE-1:0]  mem [NUM_INS];

    logic                  write_en;
    logic                  last_write;
    logic                  start_load;
    logic                  fetch_go;
    logic                  pc_in_range;
    logic [WORD_SIZE-1:0]  rd_word;
    logic                  rd_perr;

    assign load_ready  = (state_q == S_LOAD);
    assign busy        = (state_q != S_READY);
    assign write_en    = load_valid && load_ready && !rst;
    assign last_write  = write_en && (ptr_q == LAST_IDX);
    assign start_load  = load_start && (state_q != S_LOAD);
    // A load request in READY wins over a coincident fetch.
    assign fetch_go    = (state_q == S_READY) && fetch_en && !load_start;
    assign pc_in_range = ({1'b0, prog_count} < NUM_INS_W);
    assign rd_word     = pc_in_range ? mem[prog_count] : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_start) state_d = S_LOAD;
            S_LOAD:  if (last_write) state_d = S_READY;
            S_READY: if (load_start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer parks on the last index instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= last_write;
            if (start_load) begin
                ptr_q <= '0;
            end else if (write_en && !last_write) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Storage has no reset; the FSM returning to IDLE is what invalidates it.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[ptr_q] <= load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [NUM_INS];

    always_ff @(posedge clk) begin
        if (write_en) begin
            par_mem[ptr_q] <= (^load_data) ^ load_par_inv;
        end
    end

    assign rd_perr = pc_in_range && ((^mem[prog_count]) != par_mem[prog_count]);
`else
    logic unused_par_inv;
    assign unused_par_inv = load_par_inv;
    assign rd_perr        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_val    <= '0;
            ins_valid  <= 1'b0;
            parity_err <= 1'b0;
        end else if (fetch_go) begin
            ins_val    <= rd_word;
            ins_valid  <= 1'b1;
            parity_err <= rd_perr;
        end else begin
            ins_valid  <= 1'b0;
            parity_err <= 1'b0;
        end
    end

endmodule
